// File: rtl/dll_code_ctrl.sv
// DLL delay-code controller: filters phase-detector pulses over a window,
// steps the delay code by +/-1 per window, publishes binary/gray/half-gray
// codes, and tracks lock with a reversal/dead-band criterion.
module dll_code_ctrl #(
  parameter int unsigned CODE_W     = 10,
  parameter int unsigned INIT_CODE  = 512,
  parameter int unsigned FILT_N     = 8,
  parameter int unsigned FILT_TH    = 3,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned LOCK_REV   = 4
) (
  input  logic              clk_pll,
  input  logic              rst_n,
  input  logic              lock_req,
  input  logic              t_up,
  input  logic              t_down,
  input  logic              track_en,
  input  logic              ovrd_en,
  input  logic [CODE_W-1:0] ovrd_code,
  output logic [CODE_W-1:0] code_bin,
  output logic [CODE_W-1:0] code_gray,
  output logic [CODE_W-1:0] half_gray,
  output logic              code_valid,
  output logic              dll_lock,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic [2:0]        state
);

  // Signed accumulator holds +/-FILT_N; counters sized to their limits.
  localparam int unsigned ACC_W = $clog2(FILT_N + 1) + 1;
  localparam int unsigned SMP_W = $clog2(FILT_N);
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned CNT_W = $clog2(LOCK_REV + 1);

  localparam logic [CODE_W-1:0] INIT_BIN  = CODE_W'(INIT_CODE);
  localparam logic [CODE_W-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
  localparam logic [CODE_W-1:0] INIT_HALF = (INIT_BIN >> 1) ^ (INIT_BIN >> 2);
  localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};

  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC - 1);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(FILT_N - 1);
  localparam logic [CNT_W-1:0] LOCK_LIM  = CNT_W'(LOCK_REV);

  localparam logic signed [ACC_W-1:0] TH_P     = ACC_W'(FILT_TH);
  localparam logic signed [ACC_W-1:0] TH_N     = -TH_P;
  localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MONE = -ACC_ONE;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_UPDATE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_OVRD   = 3'd5
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [CODE_W-1:0]        r_code, w_code_nxt;
  logic [CODE_W-1:0]        r_gray;
  logic [CODE_W-1:0]        r_half;
  logic                     r_valid, w_valid_nxt;
  logic                     r_lock, w_lock_nxt;
  logic                     r_sat_hi, w_sat_hi_nxt;
  logic                     r_sat_lo, w_sat_lo_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [SMP_W-1:0]         r_smp, w_smp_nxt;
  logic [SET_W-1:0]         r_settle, w_settle_nxt;
  logic [CNT_W-1:0]         r_rev, w_rev_nxt;
  logic [CNT_W-1:0]         r_run, w_run_nxt;
  logic                     r_last_up, w_last_up_nxt;
  logic                     r_last_dn, w_last_dn_nxt;

  logic signed [ACC_W-1:0]  w_smp_val;
  logic                     w_dir_up;
  logic                     w_dir_dn;
  logic                     w_reversal;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LOCK_LIM) ? v : v + CNT_W'(1);
  endfunction

  // Per-sample vote: conflicting or absent pulses contribute nothing.
  assign w_smp_val = (t_up && !t_down) ? ACC_ONE  :
                     (t_down && !t_up) ? ACC_MONE : '0;

  // Window decision and direction-reversal detection against last_dir.
  assign w_dir_up   = (r_acc >= TH_P);
  assign w_dir_dn   = (r_acc <= TH_N);
  assign w_reversal = (w_dir_up || w_dir_dn) && (r_last_up || r_last_dn) &&
                      (w_dir_up != r_last_up);

  // Next-state and datapath next values; everything holds unless changed.
  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_valid_nxt   = r_valid;
    w_lock_nxt    = r_lock;
    w_sat_hi_nxt  = r_sat_hi;
    w_sat_lo_nxt  = r_sat_lo;
    w_acc_nxt     = r_acc;
    w_smp_nxt     = r_smp;
    w_settle_nxt  = r_settle;
    w_rev_nxt     = r_rev;
    w_run_nxt     = r_run;
    w_last_up_nxt = r_last_up;
    w_last_dn_nxt = r_last_dn;

    if (ovrd_en) begin
      w_state_nxt  = ST_OVRD;
      w_code_nxt   = ovrd_code;
      w_valid_nxt  = 1'b1;
      w_lock_nxt   = 1'b0;
      w_acc_nxt    = '0;
      w_smp_nxt    = '0;
      w_settle_nxt = '0;
      w_rev_nxt    = '0;
      w_run_nxt    = '0;
    end else if (!lock_req) begin
      w_state_nxt  = ST_IDLE;
      w_valid_nxt  = 1'b0;
      w_lock_nxt   = 1'b0;
      w_acc_nxt    = '0;
      w_smp_nxt    = '0;
      w_settle_nxt = '0;
      w_rev_nxt    = '0;
      w_run_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = SETTLE_LD;
        end

        ST_SETTLE: begin
          if (r_settle == '0) begin
            w_state_nxt = ST_SAMPLE;
            w_acc_nxt   = '0;
            w_smp_nxt   = '0;
          end else begin
            w_settle_nxt = r_settle - SET_W'(1);
          end
        end

        ST_SAMPLE: begin
          w_acc_nxt = r_acc + w_smp_val;
          if (r_smp == SMP_LAST) begin
            w_state_nxt = ST_UPDATE;
          end else begin
            w_smp_nxt = r_smp + SMP_W'(1);
          end
        end

        ST_UPDATE: begin
          // Clamped code step; a blocked step raises the matching sat flag.
          if (w_dir_up) begin
            if (r_code == CODE_MAX) begin
              w_sat_hi_nxt = 1'b1;
            end else begin
              w_code_nxt   = r_code + CODE_W'(1);
              w_sat_hi_nxt = 1'b0;
              w_sat_lo_nxt = 1'b0;
            end
          end else if (w_dir_dn) begin
            if (r_code == '0) begin
              w_sat_lo_nxt = 1'b1;
            end else begin
              w_code_nxt   = r_code - CODE_W'(1);
              w_sat_hi_nxt = 1'b0;
              w_sat_lo_nxt = 1'b0;
            end
          end

          // Reversal / run bookkeeping.
          if (w_dir_up || w_dir_dn) begin
            if (w_reversal) begin
              w_rev_nxt = sat_inc(r_rev);
              w_run_nxt = CNT_W'(1);
            end else begin
              w_run_nxt = sat_inc(r_run);
            end
            w_last_up_nxt = w_dir_up;
            w_last_dn_nxt = w_dir_dn;
          end else begin
            w_rev_nxt = sat_inc(r_rev);
            w_run_nxt = '0;
          end

          // A long same-direction run overrides any accumulated reversals.
          if (w_run_nxt >= LOCK_LIM) begin
            w_rev_nxt  = '0;
            w_lock_nxt = 1'b0;
          end else if (w_rev_nxt >= LOCK_LIM) begin
            w_lock_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
          end

          if (w_lock_nxt && !track_en) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = SETTLE_LD;
          end
        end

        ST_LOCKED: begin
          if (track_en) begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = SETTLE_LD;
          end
        end

        ST_OVRD: begin
          w_state_nxt  = ST_IDLE;
          w_valid_nxt  = 1'b0;
          w_lock_nxt   = 1'b0;
          w_acc_nxt    = '0;
          w_smp_nxt    = '0;
          w_settle_nxt = '0;
          w_rev_nxt    = '0;
          w_run_nxt    = '0;
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_pll) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers; gray forms are registered alongside the binary code.
  always_ff @(posedge clk_pll) begin
    if (!rst_n) begin
      r_code    <= INIT_BIN;
      r_gray    <= INIT_GRAY;
      r_half    <= INIT_HALF;
      r_valid   <= 1'b0;
      r_lock    <= 1'b0;
      r_sat_hi  <= 1'b0;
      r_sat_lo  <= 1'b0;
      r_acc     <= '0;
      r_smp     <= '0;
      r_settle  <= '0;
      r_rev     <= '0;
      r_run     <= '0;
      r_last_up <= 1'b0;
      r_last_dn <= 1'b0;
    end else begin
      r_code    <= w_code_nxt;
      r_gray    <= bin2gray(w_code_nxt);
      r_half    <= bin2gray(w_code_nxt >> 1);
      r_valid   <= w_valid_nxt;
      r_lock    <= w_lock_nxt;
      r_sat_hi  <= w_sat_hi_nxt;
      r_sat_lo  <= w_sat_lo_nxt;
      r_acc     <= w_acc_nxt;
      r_smp     <= w_smp_nxt;
      r_settle  <= w_settle_nxt;
      r_rev     <= w_rev_nxt;
      r_run     <= w_run_nxt;
      r_last_up <= w_last_up_nxt;
      r_last_dn <= w_last_dn_nxt;
    end
  end

  assign code_bin   = r_code;
  assign code_gray  = r_gray;
  assign half_gray  = r_half;
  assign code_valid = r_valid;
  assign dll_lock   = r_lock;
  assign sat_hi     = r_sat_hi;
  assign sat_lo     = r_sat_lo;
  assign state      = r_state;

endmodule

// File: tb/tb_dll_code_ctrl.sv
// Testbench for dll_code_ctrl: directed phases with randomized windows,
// checked against a window-level model of the stepping and lock rules.
module tb_dll_code_ctrl;

  localparam int CODE_W     = 10;
  localparam int INIT_CODE  = 512;
  localparam int FILT_N     = 8;
  localparam int FILT_TH    = 3;
  localparam int SETTLE_CYC = 8;
  localparam int LOCK_REV   = 4;
  localparam int CODE_MAX   = (1 << CODE_W) - 1;
  localparam int PERIOD     = SETTLE_CYC + FILT_N + 1;

  localparam int M_UP   = 0;
  localparam int M_DN   = 1;
  localparam int M_RAND = 2;
  localparam int M_DEAD = 3;

  logic              clk_pll = 1'b0;
  logic              rst_n;
  logic              lock_req;
  logic              t_up;
  logic              t_down;
  logic              track_en;
  logic              ovrd_en;
  logic [CODE_W-1:0] ovrd_code;
  logic [CODE_W-1:0] code_bin;
  logic [CODE_W-1:0] code_gray;
  logic [CODE_W-1:0] half_gray;
  logic              code_valid;
  logic              dll_lock;
  logic              sat_hi;
  logic              sat_lo;
  logic [2:0]        state;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state, kept at decision-window granularity.
  int m_code, m_valid, m_lock, m_sat_hi, m_sat_lo, m_rev, m_run, m_last;

  always #5 clk_pll = ~clk_pll;

  dll_code_ctrl #(
    .CODE_W    (CODE_W),
    .INIT_CODE (INIT_CODE),
    .FILT_N    (FILT_N),
    .FILT_TH   (FILT_TH),
    .SETTLE_CYC(SETTLE_CYC),
    .LOCK_REV  (LOCK_REV)
  ) dut (
    .clk_pll   (clk_pll),
    .rst_n     (rst_n),
    .lock_req  (lock_req),
    .t_up      (t_up),
    .t_down    (t_down),
    .track_en  (track_en),
    .ovrd_en   (ovrd_en),
    .ovrd_code (ovrd_code),
    .code_bin  (code_bin),
    .code_gray (code_gray),
    .half_gray (half_gray),
    .code_valid(code_valid),
    .dll_lock  (dll_lock),
    .sat_hi    (sat_hi),
    .sat_lo    (sat_lo),
    .state     (state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int min_lr(input int v);
    return (v > LOCK_REV) ? LOCK_REV : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int exp_state);
    chk({tag, ".code_bin"},   32'(code_bin),   m_code);
    chk({tag, ".code_gray"},  32'(code_gray),  gray(m_code));
    chk({tag, ".half_gray"},  32'(half_gray),  gray(m_code >> 1));
    chk({tag, ".code_valid"}, 32'(code_valid), m_valid);
    chk({tag, ".dll_lock"},   32'(dll_lock),   m_lock);
    chk({tag, ".sat_hi"},     32'(sat_hi),     m_sat_hi);
    chk({tag, ".sat_lo"},     32'(sat_lo),     m_sat_lo);
    chk({tag, ".state"},      32'(state),      exp_state);
  endtask

  task automatic cyc();
    @(negedge clk_pll);
  endtask

  task automatic model_reset();
    m_code = INIT_CODE; m_valid = 0; m_lock = 0; m_sat_hi = 0; m_sat_lo = 0;
    m_rev = 0; m_run = 0; m_last = 0;
  endtask

  task automatic model_drop();
    m_valid = 0; m_lock = 0; m_rev = 0; m_run = 0;
  endtask

  // Apply one decision window with net vote count 'net'.
  task automatic model_window(input int net);
    int dir;
    dir = (net >= FILT_TH) ? 1 : ((net <= -FILT_TH) ? -1 : 0);
    if (dir == 1) begin
      if (m_code == CODE_MAX) m_sat_hi = 1;
      else begin m_code++; m_sat_hi = 0; m_sat_lo = 0; end
    end else if (dir == -1) begin
      if (m_code == 0) m_sat_lo = 1;
      else begin m_code--; m_sat_hi = 0; m_sat_lo = 0; end
    end
    if (dir != 0) begin
      if (m_last != 0 && dir != m_last) begin
        m_rev = min_lr(m_rev + 1); m_run = 1;
      end else begin
        m_run = min_lr(m_run + 1);
      end
      m_last = dir;
    end else begin
      m_rev = min_lr(m_rev + 1); m_run = 0;
    end
    if (m_run >= LOCK_REV) begin
      m_rev = 0; m_lock = 0;
    end else if (m_rev >= LOCK_REV) begin
      m_lock = 1; m_valid = 1;
    end
  endtask

  // Drive one full settle/sample/update period starting at a SETTLE entry.
  task automatic run_window(input int mode, input string tag);
    bit up_s [FILT_N];
    bit dn_s [FILT_N];
    int net, pu, pd, sel, p0, p1, exp_st, idx;
    pu = 50; pd = 50;
    sel = $urandom_range(0, 2);
    if (sel == 0) begin pu = 85; pd = 15; end
    else if (sel == 1) begin pu = 15; pd = 85; end
    for (int i = 0; i < FILT_N; i++) begin
      case (mode)
        M_UP:    begin up_s[i] = 1'b1; dn_s[i] = 1'b0; end
        M_DN:    begin up_s[i] = 1'b0; dn_s[i] = 1'b1; end
        M_RAND:  begin
          up_s[i] = ($urandom_range(0, 99) < pu);
          dn_s[i] = ($urandom_range(0, 99) < pd);
        end
        default: begin
          up_s[i] = ($urandom_range(0, 1) == 1);
          dn_s[i] = up_s[i];
        end
      endcase
    end
    if (mode == M_DEAD) begin
      p0 = $urandom_range(0, FILT_N - 1);
      p1 = $urandom_range(0, FILT_N - 1);
      while (p1 == p0) p1 = $urandom_range(0, FILT_N - 1);
      up_s[p0] = 1'b1; dn_s[p0] = 1'b0;
      up_s[p1] = 1'b1; dn_s[p1] = 1'b0;
    end
    net = 0;
    for (int i = 0; i < FILT_N; i++) begin
      if (up_s[i] && !dn_s[i]) net++;
      else if (dn_s[i] && !up_s[i]) net--;
    end
    for (int k = 0; k < PERIOD; k++) begin
      exp_st = (k < SETTLE_CYC) ? 1 : ((k < SETTLE_CYC + FILT_N) ? 2 : 3);
      chk({tag, ".phase_state"}, 32'(state), exp_st);
      chk({tag, ".code_hold"}, 32'(code_bin), m_code);
      if (exp_st == 2) begin
        idx = k - SETTLE_CYC;
        t_up = up_s[idx]; t_down = dn_s[idx];
      end else if (mode == M_UP) begin
        t_up = 1'b1; t_down = 1'b0;
      end else if (mode == M_DN) begin
        t_up = 1'b0; t_down = 1'b1;
      end else begin
        t_up = 1'($urandom_range(0, 1)); t_down = 1'($urandom_range(0, 1));
      end
      cyc();
    end
    model_window(net);
    check_outputs(tag, (m_lock == 1 && track_en == 1'b0) ? 4 : 1);
  endtask

  task automatic lead_in(input string tag);
    cyc();
    check_outputs(tag, 1);
  endtask

  task automatic ovrd_enter(input int code, input string tag);
    ovrd_en = 1'b1; ovrd_code = CODE_W'(code);
    cyc();
    m_code = code; m_valid = 1; m_lock = 0; m_rev = 0; m_run = 0;
    check_outputs(tag, 5);
  endtask

  task automatic ovrd_exit(input string tag);
    ovrd_en = 1'b0; lock_req = 1'b0;
    cyc();
    model_drop();
    check_outputs(tag, 0);
  endtask

  initial begin
    rst_n = 1'b0; lock_req = 1'b0; t_up = 1'b0; t_down = 1'b0;
    track_en = 1'b1; ovrd_en = 1'b0; ovrd_code = '0;
    model_reset();
    cyc(); cyc(); cyc();
    check_outputs("reset", 0);
    chk("reset.gray_const", 32'(code_gray), 768);
    chk("reset.half_const", 32'(half_gray), 384);

    // Reset asserted in the middle of a sample window.
    rst_n = 1'b1; lock_req = 1'b1; t_up = 1'b1;
    cyc();
    for (int i = 0; i < SETTLE_CYC + 3; i++) cyc();
    chk("rst_mid.pre_state", 32'(state), 2);
    rst_n = 1'b0;
    cyc();
    model_reset();
    check_outputs("rst_mid", 0);

    // Stepping with t_up held.
    rst_n = 1'b1;
    lead_in("step.lead");
    for (int w = 0; w < 3; w++) run_window(M_UP, "step");

    // Randomized tracking windows.
    for (int w = 0; w < 8; w++) run_window(M_RAND, "rand1");

    // Upper saturation via an override preset.
    ovrd_enter(1021, "sat.ovrd");
    ovrd_exit("sat.idle");
    lock_req = 1'b1;
    lead_in("sat.lead");
    for (int w = 0; w < 4; w++) run_window(M_UP, "sat_hi");
    run_window(M_DN, "sat_hi_clr");

    // Lower saturation.
    ovrd_enter(1, "satlo.ovrd");
    ovrd_exit("satlo.idle");
    lock_req = 1'b1;
    lead_in("satlo.lead");
    for (int w = 0; w < 3; w++) run_window(M_DN, "sat_lo");
    run_window(M_UP, "sat_lo_clr");

    // Lock on alternating windows, then freeze.
    rst_n = 1'b0;
    cyc();
    model_reset();
    check_outputs("rst2", 0);
    rst_n = 1'b1; track_en = 1'b0;
    lead_in("lock.lead");
    for (int w = 0; w < 5; w++) run_window((w % 2 == 0) ? M_UP : M_DN, "lock");
    chk("lock.locked_flag", 32'(dll_lock), 1);
    for (int i = 0; i < 30; i++) begin
      t_up = 1'($urandom_range(0, 1)); t_down = 1'b0;
      cyc();
      check_outputs("freeze", 4);
    end

    // Loss of lock while tracking.
    track_en = 1'b1;
    lead_in("unlock.lead");
    for (int w = 0; w < 4; w++) run_window(M_UP, "unlock");

    // Dead-band windows lead to lock without code movement.
    lock_req = 1'b0;
    cyc();
    model_drop();
    check_outputs("drop", 0);
    lock_req = 1'b1; track_en = 1'b0;
    lead_in("dead.lead");
    for (int w = 0; w < 4; w++) run_window(M_DEAD, "dead");

    // Override follows ovrd_code, then returns to IDLE holding the code.
    ovrd_enter(77, "ovrd77");
    for (int i = 0; i < 3; i++) ovrd_enter(int'($urandom_range(0, CODE_MAX)), "ovrd_rand");
    ovrd_enter(77, "ovrd77b");
    ovrd_exit("ovrd.idle");

    // Further randomized tracking.
    lock_req = 1'b1; track_en = 1'b1;
    lead_in("rand2.lead");
    for (int w = 0; w < 10; w++) run_window(M_RAND, "rand2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
